// File: rtl/bht_pkg.sv
// Shared types and row-index helper for the branch history table update path.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BHT_SIZE
`define BHT_SIZE 16
`endif
`ifndef SD
`define SD
`endif

package bht_pkg;

  // Row index width of the BHT; rows are selected by word-aligned PC bits.
  localparam int unsigned BHT_INDEX = $clog2(`BHT_SIZE);

  // One pending history update: the branch PC and its resolved direction.
  typedef struct packed {
    logic [`XLEN-1:0] pc;
    logic             taken;
  } bht_upd_t;

  // Row selection shared with the BHT itself so both sides agree on conflicts.
  function automatic logic [BHT_INDEX-1:0] bht_row(input logic [`XLEN-1:0] pc);
    return pc[2 +: BHT_INDEX];
  endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// Two-write / two-read circular buffer of BHT updates. Writes are compacted
// in age order; the parent decides how many head entries pop (0..2).
`ifndef XLEN
`define XLEN 32
`endif
`ifndef SD
`define SD
`endif

module bht_upd_fifo
  import bht_pkg::*;
#(
  parameter int unsigned  DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear_i,
  input  logic [1:0]           push_i,
  input  bht_upd_t [1:0]       push_data_i,
  input  logic [1:0]           pop_i,
  output bht_upd_t [1:0]       rd_data_o,
  output logic [CNT_W-1:0]     count_o
);

  bht_upd_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     head_p1_s;
  logic [PTR_W-1:0]     tail_p1_s;
  logic [1:0]           push_cnt_s;

  assign head_p1_s    = head_q + PTR_W'(1);
  assign tail_p1_s    = tail_q + PTR_W'(1);
  assign rd_data_o[0] = mem_q[head_q];
  assign rd_data_o[1] = mem_q[head_p1_s];
  assign count_o      = count_q;

  // Next-state: compacted writes at the tail, pops at the head, clear wins.
  always_comb begin
    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    push_cnt_s = {1'b0, push_i[0]} + {1'b0, push_i[1]};
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      case (push_i)
        2'b01: mem_d[tail_q] = push_data_i[0];
        2'b10: mem_d[tail_q] = push_data_i[1];
        2'b11: begin
          mem_d[tail_q]    = push_data_i[0];
          mem_d[tail_p1_s] = push_data_i[1];
        end
        default: mem_d = mem_q;
      endcase
      tail_d  = tail_q + PTR_W'(push_cnt_s);
      head_d  = head_q + PTR_W'(pop_i);
      count_d = count_q + CNT_W'(push_cnt_s) - CNT_W'(pop_i);
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clock) begin
    mem_q <= `SD mem_d;
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= `SD '0;
      tail_q  <= `SD '0;
      count_q <= `SD '0;
    end else begin
      head_q  <= `SD head_d;
      tail_q  <= `SD tail_d;
      count_q <= `SD count_d;
    end
  end

endmodule

// File: rtl/bht_update_ctrl.sv
// Schedules resolved EX branches into the two BHT write ports. Two head
// entries that hit the same BHT row are split across consecutive cycles so
// the row's history shifts in resolution order.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef SD
`define SD
`endif

module bht_update_ctrl
  import bht_pkg::*;
#(
  parameter int unsigned  QUEUE_DEPTH = 8,
  parameter int unsigned  BHT_INDEX   = bht_pkg::BHT_INDEX,
  localparam int unsigned CNT_W       = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [1:0]             ex_valid,
  input  logic [1:0][`XLEN-1:0]  ex_pc,
  input  logic [1:0]             ex_taken,
  output logic                   ex_ready,
  output logic [1:0]             bht_wr_en,
  output logic [1:0][`XLEN-1:0]  bht_pc,
  output logic [1:0]             bht_taken,
  output logic [CNT_W-1:0]       pending
);

  bht_upd_t [1:0]       push_data_s;
  bht_upd_t [1:0]       head_s;
  logic [1:0]           push_s;
  logic [1:0]           wr_en_s;
  logic [1:0]           pop_s;
  logic [CNT_W-1:0]     count_s;
  logic [BHT_INDEX-1:0] row0_s;
  logic [BHT_INDEX-1:0] row1_s;

  // Acceptance looks only at registered occupancy: room for a full pair.
  assign ex_ready = (count_s <= CNT_W'(QUEUE_DEPTH - 2));
  assign pending  = count_s;

  assign push_data_s[0] = '{pc: ex_pc[0], taken: ex_taken[0]};
  assign push_data_s[1] = '{pc: ex_pc[1], taken: ex_taken[1]};

  assign row0_s = BHT_INDEX'(bht_row(head_s[0].pc));
  assign row1_s = BHT_INDEX'(bht_row(head_s[1].pc));

  // Enqueue gating: nothing is taken in while full, flushing or in reset.
  always_comb begin
    push_s = 2'b00;
    if (ex_ready && !flush && !reset) begin
      push_s = ex_valid;
    end else begin
      push_s = 2'b00;
    end
  end

  // Issue selection: pair only when the two oldest entries hit distinct rows.
  always_comb begin
    wr_en_s = 2'b00;
    if (flush || reset) begin
      wr_en_s = 2'b00;
    end else if ((count_s >= CNT_W'(2)) && (row0_s != row1_s)) begin
      wr_en_s = 2'b11;
    end else if (count_s >= CNT_W'(1)) begin
      wr_en_s = 2'b01;
    end else begin
      wr_en_s = 2'b00;
    end
  end

  // Pop amount and write-port data; idle ports are driven to zero.
  always_comb begin
    pop_s        = {1'b0, wr_en_s[0]} + {1'b0, wr_en_s[1]};
    bht_wr_en    = wr_en_s;
    bht_pc[0]    = '0;
    bht_pc[1]    = '0;
    bht_taken    = 2'b00;
    if (wr_en_s[0]) begin
      bht_pc[0]    = head_s[0].pc;
      bht_taken[0] = head_s[0].taken;
    end else begin
      bht_pc[0]    = '0;
      bht_taken[0] = 1'b0;
    end
    if (wr_en_s[1]) begin
      bht_pc[1]    = head_s[1].pc;
      bht_taken[1] = head_s[1].taken;
    end else begin
      bht_pc[1]    = '0;
      bht_taken[1] = 1'b0;
    end
  end

  bht_upd_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (flush),
    .push_i      (push_s),
    .push_data_i (push_data_s),
    .pop_i       (pop_s),
    .rd_data_o   (head_s),
    .count_o     (count_s)
  );

endmodule
